// File: rtl/width_adj_pkg.sv
// rtl/width_adj_pkg.sv - shared state encoding and saturation limit helper for width_adj_stream
`timescale 1ns/1ps
package width_adj_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        BUSY  = ST_BUSY,
        FULL  = ST_FULL
    } state_t;

    // Two's-complement limit pattern for a word of the given width:
    // min (1000..0) when want_min is set, otherwise max (0111..1).
    // Callers keep only the low 'width' bits.
    function automatic logic [63:0] signed_limit(input int width, input logic want_min);
        logic [63:0] one;
        one = 64'd1;
        if (want_min) begin
            return one << (width - 1);
        end
        return (one << (width - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/width_adj_lane.sv
// rtl/width_adj_lane.sv - combinational extend/truncate/saturate of one channel word
`timescale 1ns/1ps
module width_adj_lane
    import width_adj_pkg::*;
#(
    parameter int WORD_WIDTH_IN  = 8,
    parameter int WORD_WIDTH_OUT = 12,
    parameter int SIGNED         = 0,
    parameter int SATURATE       = 0
) (
    input  logic [WORD_WIDTH_IN-1:0]  i_word,
    output logic [WORD_WIDTH_OUT-1:0] o_word,
    output logic                      o_overflow
);

    localparam int PAD = WORD_WIDTH_OUT - WORD_WIDTH_IN;

    generate
        if (PAD == 0) begin : g_pass
            assign o_word     = i_word;
            assign o_overflow = 1'b0;
        end else if (PAD > 0) begin : g_extend
            logic w_fill;
            assign w_fill     = (SIGNED != 0) ? i_word[WORD_WIDTH_IN-1] : 1'b0;
            assign o_word     = {{PAD{w_fill}}, i_word};
            assign o_overflow = 1'b0;
        end else begin : g_narrow
            logic                      w_ovf;
            logic [WORD_WIDTH_OUT-1:0] w_sat;
            if (SIGNED == 0) begin : g_unsigned
                // Any set bit above the kept range means the value does not fit.
                assign w_ovf = |i_word[WORD_WIDTH_IN-1:WORD_WIDTH_OUT];
                assign w_sat = '1;
            end else begin : g_signed
                localparam logic [WORD_WIDTH_OUT-1:0] SMAX =
                    WORD_WIDTH_OUT'(signed_limit(WORD_WIDTH_OUT, 1'b0));
                localparam logic [WORD_WIDTH_OUT-1:0] SMIN =
                    WORD_WIDTH_OUT'(signed_limit(WORD_WIDTH_OUT, 1'b1));
                // Dropped bits plus the new sign bit must all be copies of the sign.
                logic [WORD_WIDTH_IN-WORD_WIDTH_OUT:0] w_top;
                assign w_top = i_word[WORD_WIDTH_IN-1:WORD_WIDTH_OUT-1];
                assign w_ovf = !((&w_top) || !(|w_top));
                assign w_sat = i_word[WORD_WIDTH_IN-1] ? SMIN : SMAX;
            end
            assign o_word     = (w_ovf && (SATURATE != 0)) ? w_sat : i_word[WORD_WIDTH_OUT-1:0];
            assign o_overflow = w_ovf;
        end
    endgenerate

endmodule

// File: rtl/width_adj_stream.sv
// rtl/width_adj_stream.sv - multi-channel width adjuster behind a 2-entry valid/ready skid buffer
`timescale 1ns/1ps
module width_adj_stream
    import width_adj_pkg::*;
#(
    parameter int WORD_WIDTH_IN  = 8,
    parameter int WORD_WIDTH_OUT = 12,
    parameter int CHANNELS       = 4,
    parameter int SIGNED         = 0,
    parameter int SATURATE       = 0
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               input_valid,
    output logic                               input_ready,
    input  logic [CHANNELS*WORD_WIDTH_IN-1:0]  input_data,
    output logic                               output_valid,
    input  logic                               output_ready,
    output logic [CHANNELS*WORD_WIDTH_OUT-1:0] output_data,
    output logic [CHANNELS-1:0]                output_overflow,
    output logic                               overflow_sticky,
    input  logic                               overflow_clear
);

    localparam int DW = CHANNELS * WORD_WIDTH_OUT;

    logic [DW-1:0]       w_conv_data;
    logic [CHANNELS-1:0] w_conv_ovf;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_in_ready;
    logic [DW-1:0]       r_main_data;
    logic [CHANNELS-1:0] r_main_ovf;
    logic [DW-1:0]       r_skid_data;
    logic [CHANNELS-1:0] r_skid_ovf;
    logic                r_sticky;

    logic                w_accept;
    logic                w_out_xfer;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
            width_adj_lane #(
                .WORD_WIDTH_IN  (WORD_WIDTH_IN),
                .WORD_WIDTH_OUT (WORD_WIDTH_OUT),
                .SIGNED         (SIGNED),
                .SATURATE       (SATURATE)
            ) u_lane (
                .i_word     (input_data[k*WORD_WIDTH_IN +: WORD_WIDTH_IN]),
                .o_word     (w_conv_data[k*WORD_WIDTH_OUT +: WORD_WIDTH_OUT]),
                .o_overflow (w_conv_ovf[k])
            );
        end
    endgenerate

    assign w_accept   = input_valid && r_in_ready;
    assign w_out_xfer = (r_state != EMPTY) && output_ready;

    // Next state and which register loads, from occupancy and both handshakes.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_next_state   = BUSY;
                    w_load_main_in = 1'b1;
                end
            end
            BUSY: begin
                if (w_accept && w_out_xfer) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_next_state = FULL;
                    w_load_skid  = 1'b1;
                end else if (w_out_xfer) begin
                    w_next_state = EMPTY;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    w_next_state     = BUSY;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    // State register; input_ready is registered so output_ready never reaches it combinationally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != FULL);
        end
    end

    // Main and skid registers; main only changes on a load, so outputs hold under backpressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_main_data <= '0;
            r_main_ovf  <= '0;
            r_skid_data <= '0;
            r_skid_ovf  <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= w_conv_data;
                r_main_ovf  <= w_conv_ovf;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ovf  <= r_skid_ovf;
            end
            if (w_load_skid) begin
                r_skid_data <= w_conv_data;
                r_skid_ovf  <= w_conv_ovf;
            end
        end
    end

    // Sticky overflow: an overflowing accept outranks a clear in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= 1'b0;
        end else if (w_accept && (|w_conv_ovf)) begin
            r_sticky <= 1'b1;
        end else if (overflow_clear) begin
            r_sticky <= 1'b0;
        end
    end

    assign input_ready     = r_in_ready;
    assign output_valid    = (r_state != EMPTY);
    assign output_data     = r_main_data;
    assign output_overflow = r_main_ovf;
    assign overflow_sticky = r_sticky;

endmodule

// File: tb/tb_width_adj_stream.sv
// tb/tb_width_adj_stream.sv - scoreboard bench driving five width_adj_stream configurations in lockstep
`timescale 1ns/1ps
module tb_width_adj_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        ovf_clear = 1'b0;
    logic [15:0] in_data = 16'h0;

    always #5 clk = ~clk;

    // a: 8->12 signed extend, e: 8->12 unsigned extend,
    // b: 8->4 unsigned saturate, c: 8->4 signed saturate, d: 8->4 unsigned truncate
    logic        rdy_a, vld_a, stk_a; logic [23:0] dat_a; logic [1:0] ovf_a;
    logic        rdy_e, vld_e, stk_e; logic [23:0] dat_e; logic [1:0] ovf_e;
    logic        rdy_b, vld_b, stk_b; logic [7:0]  dat_b; logic [1:0] ovf_b;
    logic        rdy_c, vld_c, stk_c; logic [7:0]  dat_c; logic [1:0] ovf_c;
    logic        rdy_d, vld_d, stk_d; logic [7:0]  dat_d; logic [1:0] ovf_d;

    width_adj_stream #(.WORD_WIDTH_IN(8), .WORD_WIDTH_OUT(12), .CHANNELS(2), .SIGNED(1), .SATURATE(0)) u_a (
        .clock(clk), .reset_n(rst_n), .input_valid(in_valid), .input_ready(rdy_a), .input_data(in_data),
        .output_valid(vld_a), .output_ready(out_ready), .output_data(dat_a), .output_overflow(ovf_a),
        .overflow_sticky(stk_a), .overflow_clear(ovf_clear));
    width_adj_stream #(.WORD_WIDTH_IN(8), .WORD_WIDTH_OUT(12), .CHANNELS(2), .SIGNED(0), .SATURATE(0)) u_e (
        .clock(clk), .reset_n(rst_n), .input_valid(in_valid), .input_ready(rdy_e), .input_data(in_data),
        .output_valid(vld_e), .output_ready(out_ready), .output_data(dat_e), .output_overflow(ovf_e),
        .overflow_sticky(stk_e), .overflow_clear(ovf_clear));
    width_adj_stream #(.WORD_WIDTH_IN(8), .WORD_WIDTH_OUT(4), .CHANNELS(2), .SIGNED(0), .SATURATE(1)) u_b (
        .clock(clk), .reset_n(rst_n), .input_valid(in_valid), .input_ready(rdy_b), .input_data(in_data),
        .output_valid(vld_b), .output_ready(out_ready), .output_data(dat_b), .output_overflow(ovf_b),
        .overflow_sticky(stk_b), .overflow_clear(ovf_clear));
    width_adj_stream #(.WORD_WIDTH_IN(8), .WORD_WIDTH_OUT(4), .CHANNELS(2), .SIGNED(1), .SATURATE(1)) u_c (
        .clock(clk), .reset_n(rst_n), .input_valid(in_valid), .input_ready(rdy_c), .input_data(in_data),
        .output_valid(vld_c), .output_ready(out_ready), .output_data(dat_c), .output_overflow(ovf_c),
        .overflow_sticky(stk_c), .overflow_clear(ovf_clear));
    width_adj_stream #(.WORD_WIDTH_IN(8), .WORD_WIDTH_OUT(4), .CHANNELS(2), .SIGNED(0), .SATURATE(0)) u_d (
        .clock(clk), .reset_n(rst_n), .input_valid(in_valid), .input_ready(rdy_d), .input_data(in_data),
        .output_valid(vld_d), .output_ready(out_ready), .output_data(dat_d), .output_overflow(ovf_d),
        .overflow_sticky(stk_d), .overflow_clear(ovf_clear));

    typedef struct packed {
        logic [15:0] din;
        logic [23:0] a_d;
        logic [23:0] e_d;
        logic [7:0]  b_d; logic [1:0] b_o;
        logic [7:0]  c_d; logic [1:0] c_o;
        logic [7:0]  d_d; logic [1:0] d_o;
    } vec_t;

    vec_t vecs [7];
    vec_t exp_q [$];
    vec_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic to_grid();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) to_grid();
    endtask

    // Present a vector and hold it until accepted; expected results are queued at acceptance.
    task automatic send(input int idx);
        in_valid = 1'b1;
        in_data  = vecs[idx].din;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy_a) begin
                exp_q.push_back(vecs[idx]);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every output transfer pops the oldest expectation and compares all instances.
    always @(negedge clk) begin
        if (rst_n && vld_a && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_a", 32'({ovf_a, dat_a}), 32'({2'b00, mon_e.a_d}));
                check("out_e", 32'({ovf_e, dat_e}), 32'({2'b00, mon_e.e_d}));
                check("out_b", 32'({ovf_b, dat_b}), 32'({mon_e.b_o, mon_e.b_d}));
                check("out_c", 32'({ovf_c, dat_c}), 32'({mon_e.c_o, mon_e.c_d}));
                check("out_d", 32'({ovf_d, dat_d}), 32'({mon_e.d_o, mon_e.d_d}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        vecs[0] = '{16'h807F, 24'hF8007F, 24'h08007F, 8'hFF, 2'b11, 8'h87, 2'b11, 8'h0F, 2'b11};
        vecs[1] = '{16'h1F0A, 24'h01F00A, 24'h01F00A, 8'hFA, 2'b10, 8'h77, 2'b11, 8'hFA, 2'b10};
        vecs[2] = '{16'h0708, 24'h007008, 24'h007008, 8'h78, 2'b00, 8'h77, 2'b01, 8'h78, 2'b00};
        vecs[3] = '{16'hF8F7, 24'hFF8FF7, 24'h0F80F7, 8'hFF, 2'b11, 8'h88, 2'b01, 8'h87, 2'b11};
        vecs[4] = '{16'h0000, 24'h000000, 24'h000000, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00};
        vecs[5] = '{16'hFF01, 24'hFFF001, 24'h0FF001, 8'hF1, 2'b10, 8'hF1, 2'b00, 8'hF1, 2'b10};
        vecs[6] = '{16'h7F80, 24'h07FF80, 24'h07F080, 8'hFF, 2'b11, 8'h78, 2'b11, 8'hF0, 2'b11};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(vld_a), 32'd0);
        check("rst_ready", 32'(rdy_a), 32'd1);
        check("rst_data", 32'(dat_a), 32'd0);
        check("rst_ovf", 32'(ovf_b), 32'd0);
        check("rst_sticky", 32'(stk_b), 32'd0);
        to_grid();

        // Latency 1, valid for exactly one cycle, no sticky from a clean word.
        out_ready = 1'b1;
        send(4);
        @(negedge clk);
        check("lat_valid", 32'(vld_a), 32'd1);
        check("clean_sticky", 32'(stk_b), 32'd0);
        @(negedge clk);
        check("one_cycle_valid", 32'(vld_a), 32'd0);
        to_grid();

        // Overflowing word sets sticky on narrowing instances only.
        send(0);
        @(negedge clk);
        check("sticky_b_set", 32'(stk_b), 32'd1);
        check("sticky_c_set", 32'(stk_c), 32'd1);
        check("sticky_a_clean", 32'(stk_a), 32'd0);
        to_grid();

        // Back-to-back stream at one word per cycle.
        t0 = $time;
        send(1); send(2); send(3); send(5); send(6);
        check("throughput", 32'($time - t0), 32'd50);
        cyc(3);
        check("sticky_held", 32'(stk_b), 32'd1);

        // Clear alone.
        ovf_clear = 1'b1;
        cyc(1);
        ovf_clear = 1'b0;
        @(negedge clk);
        check("clear_b", 32'(stk_b), 32'd0);
        check("clear_c", 32'(stk_c), 32'd0);
        to_grid();

        // Set and clear together: set wins; then clear alone.
        ovf_clear = 1'b1;
        send(1);
        ovf_clear = 1'b0;
        @(negedge clk);
        check("set_wins", 32'(stk_b), 32'd1);
        to_grid();
        ovf_clear = 1'b1;
        cyc(1);
        ovf_clear = 1'b0;
        @(negedge clk);
        check("clear_after", 32'(stk_b), 32'd0);
        to_grid();
        drain();

        // Backpressure: A in main, B in skid, C held off.
        out_ready = 1'b0;
        send(2);
        send(3);
        @(negedge clk);
        check("bp_ready_low", 32'(rdy_a), 32'd0);
        check("bp_valid", 32'(vld_a), 32'd1);
        to_grid();
        in_valid = 1'b1;
        in_data  = vecs[5].din;
        cyc(3);
        @(negedge clk);
        check("bp_still_full", 32'(rdy_a), 32'd0);
        check("bp_hold_a", 32'(dat_a), 32'(vecs[2].a_d));
        check("bp_hold_b", 32'({ovf_b, dat_b}), 32'({vecs[2].b_o, vecs[2].b_d}));
        to_grid();
        out_ready = 1'b1;
        send(5);
        drain();

        // Asynchronous reset while FULL discards both buffered words.
        out_ready = 1'b0;
        send(0);
        send(1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(vld_a), 32'd0);
        check("arst_ready", 32'(rdy_a), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        to_grid();
        cyc(2);
        @(negedge clk);
        check("post_rst_valid", 32'(vld_a), 32'd0);
        check("post_rst_data", 32'(dat_a), 32'd0);
        check("post_rst_ready", 32'(rdy_a), 32'd1);
        to_grid();
        send(6);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/width_adj_stream.md
Name: width_adj_stream

Overview:
Registered, multi-channel successor to the combinational width adjuster. It takes CHANNELS packed words of WORD_WIDTH_IN and extends or narrows each one to WORD_WIDTH_OUT. Extension is signed or unsigned. Narrowing either truncates or saturates. Words move through a 2-entry valid/ready skid buffer, and overflow is flagged per word and in a sticky bit. The block sits between stream stages of different arithmetic widths, e.g. ADC samples feeding a wider accumulator, or accumulators feeding a narrow DAC.

Parameters:
WORD_WIDTH_IN, 8, width of each input channel word.
WORD_WIDTH_OUT, 12, width of each output channel word; must be >= 1.
CHANNELS, 4, number of independent words per transfer; must be >= 1.
SIGNED, 0, nonzero: two's-complement extension and saturation.
SATURATE, 0, nonzero: clamp on narrowing overflow; zero: truncate.

Ports:
clock  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
input_valid  input  1  input_data is valid.
input_ready  output  1  block can accept; transfer occurs when input_valid && input_ready.
input_data  input  CHANNELS*WORD_WIDTH_IN  channel k occupies bits [k*WORD_WIDTH_IN +: WORD_WIDTH_IN].
output_valid  output  1  output_data is valid.
output_ready  input  1  downstream accepts; transfer occurs when output_valid && output_ready.
output_data  output  CHANNELS*WORD_WIDTH_OUT  adjusted words, packed the same way as input_data.
output_overflow  output  CHANNELS  per-channel overflow, aligned with output_data.
overflow_sticky  output  1  set by any accepted word with overflow.
overflow_clear  input  1  synchronous clear of overflow_sticky.

Behaviour:
- Reset (reset_n low, asynchronous): output_valid=0, input_ready=1, output_data=0, output_overflow=0, overflow_sticky=0, state EMPTY. Deasserting reset_n mid-transfer discards all buffered words; nothing is replayed.
- Conversion is combinational on input_data. Its result and overflow bits are captured together at input acceptance.
- PAD = WORD_WIDTH_OUT - WORD_WIDTH_IN.
  - PAD = 0: pass-through; overflow is always 0.
  - PAD > 0: zero-extend, or sign-extend when SIGNED!=0; overflow is always 0.
  - PAD < 0, unsigned: overflow = |in[WORD_WIDTH_IN-1:WORD_WIDTH_OUT].
  - PAD < 0, signed: overflow = the dropped bits plus the new MSB are not all equal.
  - On overflow, SATURATE=0 emits in[WORD_WIDTH_OUT-1:0].
  - On overflow, SATURATE!=0 emits all-ones (unsigned), max positive 0111..1 (signed, input MSB=0), or min negative 1000..0 (signed, input MSB=1).
- Skid buffer: main register drives the outputs; a skid register holds one extra word.
  - input_ready = !skid_valid, registered (no combinational path from output_ready).
  - Latency: input accepted at edge N appears on output_valid after edge N; 1 cycle.
  - Throughput: 1 word/cycle while output_ready stays high.
- States and transitions:
  - EMPTY: accept -> BUSY.
  - BUSY:
    - accept and no output transfer -> FULL (word goes to skid).
    - accept and output transfer -> BUSY (main reloads).
    - output transfer only -> EMPTY.
  - FULL (input_ready=0):
    - output transfer moves skid to main -> BUSY.
    - input_valid is ignored.
- output_data and output_overflow hold stable while output_valid && !output_ready.
- Sticky flag: set at input acceptance if any channel overflows. overflow_clear clears it. If set and clear happen in the same cycle, set wins.
- Channels are fully independent; one channel overflowing does not affect the others.

Decomposition:
- Shared package width_adj_pkg holds:
  - state encoding (EMPTY, BUSY, FULL; 2-bit localparams);
  - a helper function returning the signed max and min patterns for a given width.
- Sub-module width_adj_lane: combinational per-channel extend/truncate/saturate plus overflow bit. It is instantiated CHANNELS times in a generate loop.
- The skid buffer, state machine and sticky flag live in width_adj_stream.

Test Plan:
- IN=8, OUT=12, SIGNED=1, CH=2: send 0x80_7F with output_ready=1. Next cycle output_data=0xF80_07F, overflow=00, valid for exactly 1 cycle.
- IN=8, OUT=4, SIGNED=0, SATURATE=1: send 0x1F, 0x0A. Outputs are 0xF (overflow=1) then 0xA (overflow=0). overflow_sticky=1 and stays 1 until overflow_clear.
- IN=8, OUT=4, SIGNED=1, SATURATE=1: inputs 0x07, 0x08, 0xF8, 0xF7 produce 0x7/0, 0x7/1, 0x8/0, 0x8/1.
- Backpressure: hold output_ready=0 and stream words A, B, C.
  - A sits in main and B in skid; input_ready drops after B; C is held off.
  - Raise output_ready: A, B, C arrive in order, with no loss or duplication.
- Assert overflow_clear in the same cycle an overflowing word is accepted: overflow_sticky is 1 afterwards. Clear alone the next cycle: it becomes 0.
- Assert reset_n low while in FULL: output_valid falls to 0 immediately (asynchronous). After release input_ready=1 and there is no stale output.
